note_sequencer_ctrl: RTL and testbench
======================================

// Module: note_sequencer_ctrl
// PURPOSE
//  Sequencer for the music player's 8-bit down-counter datapath. Walks a note table
//  (period, length), loads a tone counter and a duration counter per note, and drives
//  the square-wave tone output. Sits between the song ROM and the speaker output stage.
// PARAMETERS
//  ADDR_W     5  note-table address width (song up to 2**ADDR_W notes)
//  GAP_BEATS  1  silent beats inserted after each note (0 = legato, no gap)
// PORTS
//  clk          in   1       system clock; all state changes on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       1-cycle pulse: begin song at address 0 (ignored unless IDLE)
//  stop         in   1       abort playback, return to IDLE
//  pause        in   1       level: freeze playback while high
//  loop_en      in   1       level: restart at address 0 instead of finishing
//  beat_tick    in   1       1-cycle pulse per beat, from the tempo divider
//  last_addr    in   ADDR_W  address of final note in the song
//  note_period  in   8       tone half-period code of note at note_addr (0 = rest)
//  note_len     in   8       note length in beats (0 = skip note)
//  note_addr    out  ADDR_W  note-table read address (combinational ROM, same-cycle data)
//  tone_out     out  1       square-wave audio output
//  playing      out  1       high in FETCH/PLAY/GAP
//  song_done    out  1       1-cycle pulse when the song ends (not pulsed on stop)
// BEHAVIOUR
//  Reset: state=IDLE, note_addr=0, tone_out=0, playing=0, song_done=0, counters=0.
//  Priority each cycle: rst > stop > pause > start/normal progress.
//  IDLE : tone_out=0. start -> FETCH, note_addr=0.
//  FETCH: one cycle. Load tone_cnt<=note_period, dur_cnt<=note_len, tone_out<=0.
//         note_len==0 -> ADVANCE directly; else -> PLAY.
//  PLAY : tone_cnt decrements every clk; at 0: toggle tone_out, reload note_period
//         -> tone_out toggles every note_period+1 clks. note_period==0: tone_out held 0.
//         beat_tick decrements dur_cnt; beat_tick with dur_cnt==1 -> GAP (GAP_BEATS>0)
//         or ADVANCE (GAP_BEATS==0); tone_out<=0 on exit.
//  GAP  : tone_out=0; gap counter loaded with GAP_BEATS on entry, decremented per
//         beat_tick; reaching 0 -> ADVANCE.
//  ADVANCE (transition, not a state): note_addr==last_addr ->
//         loop_en ? (note_addr<=0, FETCH) : (DONE); else note_addr<=note_addr+1, FETCH.
//  DONE : one cycle, song_done=1, tone_out=0 -> IDLE; note_addr keeps last value
//         until next start.
//  pause=1 in FETCH/PLAY/GAP: state, note_addr and all counters hold, tone_out forced 0,
//         beat_tick ignored; on release playback resumes the same cycle without reload.
//  stop=1 in any state: next cycle IDLE, note_addr=0, tone_out=0, no song_done pulse.
//  start while not IDLE: ignored. start and stop same cycle: stop wins.
//  note_addr wraps only via loop_en; never increments past last_addr.
//  Counters are 8-bit unsigned, no wrap: a zero counter is reloaded, never decremented.
// STRUCTURE
//  Shared package: state encoding constants (ST_IDLE, ST_FETCH, ST_PLAY, ST_GAP, ST_DONE),
//  8-bit counter width constant. Sub-module: down_counter_8b (load, en, count, zero),
//  instantiated twice (tone_cnt, dur_cnt); gap counter and FSM inline.
// TESTING
//  1) rst, then 3-note table {(4,2),(0,1),(2,1)}, last_addr=2, beat_tick every 40 clks,
//     start -> tone toggles every 5 clks for note 0, tone_out=0 for note 1, toggles every
//     3 clks for note 2; one GAP beat silent between notes; song_done pulses once; IDLE.
//  2) note_len=0 at addr 1 -> FETCH of addr 1 followed directly by FETCH of addr 2,
//     no PLAY cycle, tone_out stays 0.
//  3) pause high for 20 clks mid-PLAY -> tone_out=0, note_addr/dur_cnt unchanged;
//     release -> waveform resumes with remaining tone_cnt, total beats unchanged.
//  4) stop asserted in GAP of note 1 -> next cycle playing=0, note_addr=0, tone_out=0,
//     song_done never pulses.
//  5) loop_en=1, last_addr=1 -> after note 1 note_addr returns to 0, FETCH, no song_done;
//     deassert loop_en -> next end gives song_done pulse.
//  6) rst asserted mid-PLAY -> next cycle all outputs at reset values; start while
//     playing ignored (note_addr unchanged); GAP_BEATS=0 build plays notes back-to-back.

Source files
------------

// File: rtl/note_sequencer_ctrl_pkg.sv
// Shared types for the note sequencer: FSM state encoding and counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package note_sequencer_ctrl_pkg;

    // All datapath counters (tone, duration, gap) are this wide, unsigned.
    localparam int CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PLAY  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // States in which a song is considered to be in progress.
    function automatic logic is_active(input state_t s);
        return (s == ST_FETCH) || (s == ST_PLAY) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/down_counter_8b.sv
// 8-bit loadable down-counter with zero flag; never wraps below zero.
// Latency: count updates one clk after load/en; zero is combinational from count.
// Backpressure: none; en is simply ignored while the count is zero.
module down_counter_8b
    import note_sequencer_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Load takes priority over decrement; a zero count holds until reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - cnt_t'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/note_sequencer_ctrl.sv
// Walks the note table, drives tone/duration counters and the square-wave tone output.
// Latency: note_addr is presented one clk before the note is loaded (FETCH); tone edges are registered.
// Backpressure: pause freezes all sequencing state; stop aborts to IDLE without a done pulse.
module note_sequencer_ctrl
    import note_sequencer_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int GAP_BEATS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic              beat_tick,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [7:0]        note_period,
    input  logic [7:0]        note_len,
    output logic [ADDR_W-1:0] note_addr,
    output logic              tone_out,
    output logic              playing,
    output logic              song_done
);

    localparam bit   HAS_GAP  = (GAP_BEATS > 0);
    localparam cnt_t GAP_LOAD = cnt_t'(GAP_BEATS);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              tone_q, tone_nxt;
    cnt_t              gap_cnt, gap_nxt;

    logic              tone_ld, tone_en, tone_zero;
    logic              dur_ld, dur_en, dur_zero;
    cnt_t              tone_cnt, dur_cnt;
    logic              dur_last;
    logic              advance;

    // Only the tone counter's zero flag drives the waveform; its value is not needed.
    logic              tone_cnt_unused;
    assign tone_cnt_unused = ^tone_cnt;

    down_counter_8b u_tone_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (tone_ld),
        .load_val (note_period),
        .en       (tone_en),
        .count    (tone_cnt),
        .zero     (tone_zero)
    );

    down_counter_8b u_dur_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (dur_ld),
        .load_val (note_len),
        .en       (dur_en),
        .count    (dur_cnt),
        .zero     (dur_zero)
    );

    // A zero duration while in PLAY cannot normally occur; end the note on the next beat.
    assign dur_last = (dur_cnt == cnt_t'(1)) || dur_zero;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address, tone level and gap counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            tone_q  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            addr_q  <= addr_nxt;
            tone_q  <= tone_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Next-state, counter controls and note advance; stop overrides, pause freezes.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        tone_nxt  = tone_q;
        gap_nxt   = gap_cnt;
        tone_ld   = 1'b0;
        tone_en   = 1'b0;
        dur_ld    = 1'b0;
        dur_en    = 1'b0;
        advance   = 1'b0;

        if (stop) begin
            state_nxt = ST_IDLE;
            addr_nxt  = '0;
            tone_nxt  = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    tone_nxt = 1'b0;
                    if (start) begin
                        state_nxt = ST_FETCH;
                        addr_nxt  = '0;
                    end
                end
                ST_FETCH: begin
                    if (!pause) begin
                        tone_ld  = 1'b1;
                        dur_ld   = 1'b1;
                        tone_nxt = 1'b0;
                        if (note_len == '0) begin
                            advance = 1'b1;
                        end else begin
                            state_nxt = ST_PLAY;
                        end
                    end
                end
                ST_PLAY: begin
                    if (!pause) begin
                        // Half-period is note_period+1 clks: count down, toggle and reload at zero.
                        if (tone_zero) begin
                            tone_ld = 1'b1;
                            if (note_period != '0) begin
                                tone_nxt = ~tone_q;
                            end
                        end else begin
                            tone_en = 1'b1;
                        end
                        if (beat_tick) begin
                            dur_en = 1'b1;
                            if (dur_last) begin
                                tone_nxt = 1'b0;
                                if (HAS_GAP) begin
                                    state_nxt = ST_GAP;
                                    gap_nxt   = GAP_LOAD;
                                end else begin
                                    advance = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_GAP: begin
                    tone_nxt = 1'b0;
                    if (!pause && beat_tick) begin
                        if (gap_cnt <= cnt_t'(1)) begin
                            gap_nxt = '0;
                            advance = 1'b1;
                        end else begin
                            gap_nxt = gap_cnt - cnt_t'(1);
                        end
                    end
                end
                ST_DONE: begin
                    tone_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    addr_nxt  = '0;
                    tone_nxt  = 1'b0;
                end
            endcase

            // Move to the next note, wrap on loop, or finish after the last one.
            if (advance) begin
                if (addr_q == last_addr) begin
                    if (loop_en) begin
                        addr_nxt  = '0;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    addr_nxt  = addr_q + ADDR_W'(1);
                    state_nxt = ST_FETCH;
                end
            end
        end
    end

    assign note_addr = addr_q;
    assign playing   = is_active(state);
    assign song_done = (state == ST_DONE);
    // The held tone level is masked while paused so it resumes cleanly on release.
    assign tone_out  = tone_q && (state == ST_PLAY) && !pause;

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
module tb_note_sequencer_ctrl;

    localparam int ADDR_W = 5;
    localparam int BEAT_P = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              start2 = 1'b0;
    logic              stop = 1'b0;
    logic              pause = 1'b0;
    logic              loop_en = 1'b0;
    logic              beat_tick = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [7:0]        note_period, note_len, note_period2, note_len2;
    logic [ADDR_W-1:0] note_addr, note_addr2;
    logic              tone_out, playing, song_done;
    logic              tone_out2, playing2, song_done2;

    logic [7:0] rom_p [0:31];
    logic [7:0] rom_l [0:31];

    assign note_period  = rom_p[note_addr];
    assign note_len     = rom_l[note_addr];
    assign note_period2 = rom_p[note_addr2];
    assign note_len2    = rom_l[note_addr2];

    always #5 clk = ~clk;

    note_sequencer_ctrl #(.ADDR_W(ADDR_W), .GAP_BEATS(1)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .beat_tick(beat_tick), .last_addr(last_addr),
        .note_period(note_period), .note_len(note_len), .note_addr(note_addr),
        .tone_out(tone_out), .playing(playing), .song_done(song_done)
    );

    note_sequencer_ctrl #(.ADDR_W(ADDR_W), .GAP_BEATS(0)) dut_legato (
        .clk(clk), .rst(rst), .start(start2), .stop(stop), .pause(pause),
        .loop_en(loop_en), .beat_tick(beat_tick), .last_addr(last_addr),
        .note_period(note_period2), .note_len(note_len2), .note_addr(note_addr2),
        .tone_out(tone_out2), .playing(playing2), .song_done(song_done2)
    );

    // kind 0 = note segment, 1 = song_done pulse
    typedef struct {
        int kind;
        int addr;
        int beats;
        int tone;
        int iv;
        int cyc;
    } ev_t;

    ev_t sbq[$];
    ev_t sbq2[$];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Expected record for a note played to completion on the gapped instance.
    task automatic push_note(input int addr, input int period, input int len);
        ev_t e;
        e.kind  = 0;
        e.addr  = addr;
        e.beats = (len == 0) ? 0 : len + 1;
        e.tone  = (period > 0 && len > 0) ? 1 : 0;
        e.iv    = (period > 0 && len > 0) ? 2 * (period + 1) : 0;
        e.cyc   = (len == 0) ? 1 : 0;
        sbq.push_back(e);
    endtask

    task automatic push_raw(input int kind, input int addr, input int beats, input int tone);
        ev_t e;
        e.kind = kind; e.addr = addr; e.beats = beats; e.tone = tone; e.iv = 0; e.cyc = 0;
        sbq.push_back(e);
    endtask

    task automatic push_legato(input int kind, input int addr, input int beats);
        ev_t e;
        e.kind = kind; e.addr = addr; e.beats = beats; e.tone = 0; e.iv = 0; e.cyc = 0;
        sbq2.push_back(e);
    endtask

    // Tempo divider: one beat_tick every BEAT_P clks while enabled.
    bit beat_en = 0;
    int beat_div = 0;
    always @(posedge clk) begin
        #1;
        if (beat_en) begin
            if (beat_div == BEAT_P - 1) begin
                beat_tick = 1'b1;
                beat_div  = 0;
            end else begin
                beat_tick = 1'b0;
                beat_div++;
            end
        end else begin
            beat_tick = 1'b0;
            beat_div  = 0;
        end
    end

    // Monitor for the gapped instance: segments per note address while playing.
    int                cyc = 0;
    bit                seg_open = 0;
    logic [ADDR_W-1:0] seg_addr;
    int                seg_ticks, seg_rises, seg_cyc, iv_min, iv_max, last_rise;
    bit                rise_vld;
    logic              prev_tone = 1'b0;

    task automatic close_seg();
        ev_t e;
        if (sbq.size() == 0) begin
            check_val("seg_unexpected", 1, 0);
            return;
        end
        e = sbq.pop_front();
        check_val("seg_kind", 0, e.kind);
        check_val("seg_addr", 32'(seg_addr), e.addr);
        check_val("seg_beats", seg_ticks, e.beats);
        check_val("seg_tone", (seg_rises > 0) ? 1 : 0, e.tone);
        if (e.iv != 0) begin
            check_val("seg_rises_ge2", (seg_rises >= 2) ? 1 : 0, 1);
            check_val("seg_iv_min", iv_min, e.iv);
            check_val("seg_iv_max", iv_max, e.iv);
        end
        if (e.cyc != 0) check_val("seg_cyc", seg_cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  iv;
        cyc++;
        if (seg_open && (playing !== 1'b1 || note_addr != seg_addr)) begin
            close_seg();
            seg_open = 0;
        end
        if (playing === 1'b1 && !seg_open) begin
            seg_open = 1; seg_addr = note_addr;
            seg_ticks = 0; seg_rises = 0; seg_cyc = 0;
            iv_min = 1000000; iv_max = 0; rise_vld = 0;
        end
        if (seg_open) begin
            seg_cyc++;
            if (beat_tick && !pause) seg_ticks++;
            if (pause) begin
                rise_vld = 0;
            end else if (tone_out === 1'b1 && prev_tone !== 1'b1) begin
                seg_rises++;
                if (rise_vld) begin
                    iv = cyc - last_rise;
                    if (iv < iv_min) iv_min = iv;
                    if (iv > iv_max) iv_max = iv;
                end
                last_rise = cyc;
                rise_vld  = 1;
            end
        end
        prev_tone = tone_out;
        if (song_done === 1'b1) begin
            if (sbq.size() == 0) begin
                check_val("done_unexpected", 1, 0);
            end else begin
                e = sbq.pop_front();
                check_val("done_kind", 1, e.kind);
            end
        end
    end

    // Monitor for the legato instance: beats per note and done pulse.
    bit                seg2_open = 0;
    logic [ADDR_W-1:0] seg2_addr;
    int                seg2_ticks;

    always @(negedge clk) begin
        ev_t e;
        if (seg2_open && (playing2 !== 1'b1 || note_addr2 != seg2_addr)) begin
            if (sbq2.size() == 0) begin
                check_val("leg_unexpected", 1, 0);
            end else begin
                e = sbq2.pop_front();
                check_val("leg_kind", 0, e.kind);
                check_val("leg_addr", 32'(seg2_addr), e.addr);
                check_val("leg_beats", seg2_ticks, e.beats);
            end
            seg2_open = 0;
        end
        if (playing2 === 1'b1 && !seg2_open) begin
            seg2_open = 1; seg2_addr = note_addr2; seg2_ticks = 0;
        end
        if (seg2_open && beat_tick && !pause) seg2_ticks++;
        if (song_done2 === 1'b1) begin
            if (sbq2.size() == 0) begin
                check_val("leg_done_unexpected", 1, 0);
            end else begin
                e = sbq2.pop_front();
                check_val("leg_done_kind", 1, e.kind);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (playing !== 1'b0 && n < max) begin
            step();
            n++;
        end
        check_val(tag, (n < max) ? 1 : 0, 1);
        repeat (3) step();
    endtask

    task automatic wait_addr(input string tag, input int addr, input int max);
        int n = 0;
        while (!(playing === 1'b1 && note_addr == ADDR_W'(addr)) && n < max) begin
            step();
            n++;
        end
        check_val(tag, (n < max) ? 1 : 0, 1);
    endtask

    task automatic set_note(input int a, input int p, input int l);
        rom_p[a] = 8'(p);
        rom_l[a] = 8'(l);
    endtask

    initial begin
        int   n;
        logic prev;
        for (int i = 0; i < 32; i++) begin
            rom_p[i] = 8'd0;
            rom_l[i] = 8'd0;
        end

        // Reset values
        repeat (3) step();
        check_val("rst_addr", 32'(note_addr), 0);
        check_val("rst_tone", 32'(tone_out), 0);
        check_val("rst_playing", 32'(playing), 0);
        check_val("rst_done", 32'(song_done), 0);
        check_val("rst_addr2", 32'(note_addr2), 0);
        check_val("rst_tone2", 32'(tone_out2), 0);
        rst = 1'b0;
        step();

        // 1) basic 3-note song, gapped and legato builds side by side
        set_note(0, 4, 2); set_note(1, 0, 1); set_note(2, 2, 1);
        last_addr = 5'd2;
        push_note(0, 4, 2); push_note(1, 0, 1); push_note(2, 2, 1); push_raw(1, 0, 0, 0);
        push_legato(0, 0, 2); push_legato(0, 1, 1); push_legato(0, 2, 1); push_legato(1, 0, 0);
        start = 1'b1; start2 = 1'b1; beat_en = 1;
        step();
        start = 1'b0; start2 = 1'b0;
        wait_addr("t1_reach_addr1", 1, 400);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("start_ignored_addr", 32'(note_addr), 1);
        check_val("start_ignored_play", 32'(playing), 1);
        wait_idle("t1_finish", 1000);
        check_val("t1_sb_empty", sbq.size(), 0);
        check_val("t1_leg_sb_empty", sbq2.size(), 0);
        check_val("t1_idle_tone2", 32'(tone_out2), 0);
        beat_en = 0;
        step();

        // 2) zero-length note is skipped with a single FETCH cycle
        set_note(0, 4, 1); set_note(1, 5, 0); set_note(2, 2, 1);
        push_note(0, 4, 1); push_note(1, 5, 0); push_note(2, 2, 1); push_raw(1, 0, 0, 0);
        start = 1'b1; beat_en = 1;
        step();
        start = 1'b0;
        wait_idle("t2_finish", 1000);
        check_val("t2_sb_empty", sbq.size(), 0);
        beat_en = 0;
        step();

        // 3) pause mid-PLAY right after a rising tone edge
        set_note(0, 4, 4); set_note(1, 2, 1);
        last_addr = 5'd1;
        push_note(0, 4, 4); push_note(1, 2, 1); push_raw(1, 0, 0, 0);
        start = 1'b1; beat_en = 1;
        step();
        start = 1'b0;
        repeat (45) step();
        prev = tone_out;
        n = 0;
        while (!(tone_out === 1'b1 && prev === 1'b0) && n < 40) begin
            prev = tone_out;
            step();
            n++;
        end
        check_val("t3_found_rise", (n < 40) ? 1 : 0, 1);
        pause = 1'b1;
        repeat (20) begin
            step();
            check_val("pause_tone", 32'(tone_out), 0);
            check_val("pause_addr", 32'(note_addr), 0);
            check_val("pause_playing", 32'(playing), 1);
        end
        pause = 1'b0;
        #1;
        check_val("resume_tone", 32'(tone_out), 1);
        n = 0;
        do begin
            step();
            n++;
        end while (tone_out === 1'b1 && n < 20);
        check_val("resume_halfperiod", n, 5);
        wait_idle("t3_finish", 1000);
        check_val("t3_sb_empty", sbq.size(), 0);
        beat_en = 0;
        step();

        // 4) stop during the gap after note 1
        set_note(0, 4, 2); set_note(1, 0, 1); set_note(2, 2, 1);
        last_addr = 5'd2;
        push_note(0, 4, 2); push_raw(0, 1, 1, 0);
        start = 1'b1; beat_en = 1;
        step();
        start = 1'b0;
        wait_addr("t4_reach_addr1", 1, 400);
        n = 0;
        while (beat_tick !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_val("t4_found_beat", (n < 100) ? 1 : 0, 1);
        repeat (5) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("stop_playing", 32'(playing), 0);
        check_val("stop_addr", 32'(note_addr), 0);
        check_val("stop_tone", 32'(tone_out), 0);
        check_val("stop_done", 32'(song_done), 0);
        repeat (100) step();
        check_val("t4_sb_empty", sbq.size(), 0);
        beat_en = 0;
        step();

        // 5) looping two-note song, then loop released
        set_note(0, 3, 1); set_note(1, 1, 1);
        last_addr = 5'd1;
        loop_en = 1'b1;
        push_note(0, 3, 1); push_note(1, 1, 1); push_note(0, 3, 1); push_note(1, 1, 1);
        push_raw(1, 0, 0, 0);
        start = 1'b1; beat_en = 1;
        step();
        start = 1'b0;
        wait_addr("t5_reach_addr1", 1, 400);
        wait_addr("t5_wrap_addr0", 0, 400);
        loop_en = 1'b0;
        wait_idle("t5_finish", 1000);
        check_val("t5_sb_empty", sbq.size(), 0);
        beat_en = 0;
        step();

        // 6) reset mid-PLAY
        set_note(0, 4, 2); set_note(1, 0, 1); set_note(2, 2, 1);
        last_addr = 5'd2;
        push_raw(0, 0, 0, 1);
        start = 1'b1; beat_en = 1;
        step();
        start = 1'b0;
        repeat (12) step();
        rst = 1'b1;
        step();
        check_val("midrst_addr", 32'(note_addr), 0);
        check_val("midrst_tone", 32'(tone_out), 0);
        check_val("midrst_playing", 32'(playing), 0);
        check_val("midrst_done", 32'(song_done), 0);
        rst = 1'b0;
        beat_en = 0;
        repeat (3) step();
        check_val("t6_sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
